// File: rtl/nibble_add_seq.sv
// Multi-cycle W-bit adder: one 4-bit ripple adder stepped across NIBBLES nibbles with a registered carry.
// Optional subtract mode (op_sub port) is built when NIBBLE_ADD_SEQ_SUB_EN is defined.

module full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Bitwise ripple chain.
  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic                 op_sub,
`endif
  input  logic                 cin_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 cout_out,
  output logic                 ovf_out,
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx;
  logic [W-1:0]    b_eff;
  logic [W-1:0]    sum_nxt;
  logic [3:0]      a_nib, b_nib, add_sum;
  logic            add_cout;
  logic            last;
  logic            ovf_nxt;
  logic            carry_init;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic sub_reg;
  assign b_eff      = sub_reg ? ~b_reg : b_reg;
  assign carry_init = op_sub ? 1'b1 : cin_in;
`else
  assign b_eff      = b_reg;
  assign carry_init = cin_in;
`endif

  // Select the active nibble of each operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx == IW'(k)) begin
        a_nib = a_reg[4*k +: 4];
        b_nib = b_eff[4*k +: 4];
      end
    end
  end

  full_adder u_full_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Merge the adder's nibble into the running sum.
  always_comb begin
    sum_nxt = sum_reg;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx == IW'(k)) sum_nxt[4*k +: 4] = add_sum;
    end
  end

  assign last    = (idx == IW'(NIBBLES - 1));
  assign ovf_nxt = (a_reg[W-1] == b_eff[W-1]) && (sum_nxt[W-1] != a_reg[W-1]);

  // Control, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      sub_reg     <= 1'b0;
`endif
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      sum_out     <= '0;
      cout_out    <= 1'b0;
      ovf_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            sum_reg     <= '0;
            carry_reg   <= carry_init;
            idx         <= '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub_reg     <= op_sub;
`endif
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          sum_reg   <= sum_nxt;
          carry_reg <= add_cout;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            res_valid <= 1'b1;
            sum_out   <= sum_nxt;
            cout_out  <= add_cout;
            ovf_out   <= ovf_nxt;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq (NIBBLES=4); subtract vectors run when NIBBLE_ADD_SEQ_SUB_EN is defined.

module tb_nibble_add_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int unsigned CW      = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;
  logic         busy;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic         op_sub;
`endif

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .op_sub      (op_sub),
`endif
    .cin_in      (cin_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_out     (sum_out),
    .cout_out    (cout_out),
    .ovf_out     (ovf_out),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one command; optionally push its expected {sum,cout,ovf}. Returns 1ns after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input bit push, input logic [W-1:0] s, input logic c, input logic o);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready_wait", CW'(start_ready), CW'(1));
    a_in = a;
    b_in = b;
    cin_in = cin;
    start_valid = 1'b1;
    if (push) exp_q.push_back({s, c, o});
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic [W-1:0] s, input logic c, input logic o);
    int cyc;
    issue(a, b, cin, 1'b1, s, c, o);
    wait_valid(cyc);
    chk("latency", CW'(cyc), CW'(NIBBLES));
    @(posedge clk); #1;
    chk("ready_after_hs", CW'({start_ready, busy, res_valid}), CW'(3'b100));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    cin_in = 1'b0;
    res_ready = 1'b1;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    op_sub = 1'b0;
`endif

    // Result monitor: pops the scoreboard on every result handshake.
    fork
      forever begin
        logic [CW-1:0] e;
        @(negedge clk);
        if (rst_n && res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result actual=%h required=none", {sum_out, cout_out, ovf_out});
          end else begin
            e = exp_q.pop_front();
            chk("result", {sum_out, cout_out, ovf_out}, e);
          end
        end
      end
    join_none

    #12;
    chk("reset_ctrl", CW'({start_ready, res_valid, busy}), CW'(3'b100));
    chk("reset_data", {sum_out, cout_out, ovf_out}, CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure in DONE with ignored commands.
    res_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    wait_valid(cyc);
    chk("bp_latency", CW'(cyc), CW'(NIBBLES));
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      a_in = 16'hABCD;
      b_in = 16'h0F0F;
      @(posedge clk); #1;
      chk("bp_hold", {sum_out, cout_out, ovf_out}, {16'h3333, 1'b0, 1'b0});
      chk("bp_ctrl", CW'({res_valid, start_ready, busy}), CW'(3'b101));
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_to_idle", CW'({res_valid, start_ready, busy}), CW'(3'b010));
    @(posedge clk); #1;
    chk("ignored_cmd", CW'({busy, res_valid}), CW'(2'b00));

    // Asynchronous reset mid-RUN with idx=2.
    issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", CW'({start_ready, res_valid, busy}), CW'(3'b100));
    chk("async_rst_data", {sum_out, cout_out, ovf_out}, CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    op_sub = 1'b1;
    run(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op_sub = 1'b0;
    run(16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("scoreboard_drained", CW'(exp_q.size()), CW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
